// File: rtl/saradc_sar_ctrl.sv
// rtl/saradc_sar_ctrl.sv - SAR sequencer driving CDAC switch groups through sample, hold and bit trials.
// Optional SARADC_SAR_CTRL_CMP_SETTLE_EN: two cycles per trial (settle, then decide).
module saradc_sar_ctrl #(
    parameter int NB    = 8,
    parameter int NSAMP = 2
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          START,
    input  logic          CMP,
    output logic [NB-1:0] CRI,
    output logic [NB-1:0] CRIB,
    output logic [NB-1:0] CRH,
    output logic [NB-1:0] CRHB,
    output logic [NB-1:0] CRL,
    output logic [NB-1:0] CRLB,
    output logic          BUSY,
    output logic          EOC,
    output logic [NB-1:0] DOUT
);

    localparam int SW = (NSAMP > 1) ? $clog2(NSAMP) : 1;
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_HOLD,
        S_CONV,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [KW-1:0] k_q, k_d;
    logic [NB-1:0] t_q, t_d;
    logic [NB-1:0] cri_q, cri_d, crh_q, crh_d, crl_q, crl_d;
    logic [NB-1:0] dout_q, dout_d;
    logic          busy_q, busy_d, eoc_q, eoc_d;
    logic          decide;
`ifdef SARADC_SAR_CTRL_CMP_SETTLE_EN
    logic          ph_q, ph_d;
`endif

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        k_d     = k_q;
        t_d     = t_q;
        dout_d  = dout_q;
`ifdef SARADC_SAR_CTRL_CMP_SETTLE_EN
        ph_d    = ph_q;
        decide  = ph_q;
`else
        decide  = 1'b1;
`endif
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_SAMPLE;
                    scnt_d  = '0;
                end
            end
            S_SAMPLE: begin
                if (scnt_q == SW'(NSAMP - 1)) state_d = S_HOLD;
                else                          scnt_d  = scnt_q + SW'(1);
            end
            S_HOLD: begin
                state_d        = S_CONV;
                t_d            = '0;
                t_d[NB-1]      = 1'b1;
                k_d            = KW'(NB - 1);
`ifdef SARADC_SAR_CTRL_CMP_SETTLE_EN
                ph_d           = 1'b0;
`endif
            end
            S_CONV: begin
`ifdef SARADC_SAR_CTRL_CMP_SETTLE_EN
                ph_d = ~ph_q;
`endif
                // CMP=1 means the trial level overshoots the input, so drop the bit
                if (decide) begin
                    t_d[k_q] = ~CMP;
                    if (k_q != '0) begin
                        t_d[k_q - KW'(1)] = 1'b1;
                        k_d               = k_q - KW'(1);
                    end else begin
                        state_d = S_DONE;
                        dout_d  = t_d;
                    end
                end
            end
            S_DONE: begin
                if (START) begin
                    state_d = S_SAMPLE;
                    scnt_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so every port comes straight off a flop
        cri_d  = (state_d == S_SAMPLE) ? '1 : '0;
        crh_d  = (state_d == S_CONV) ? t_d : '0;
        crl_d  = (state_d == S_CONV) ? ~t_d : '0;
        busy_d = (state_d != S_IDLE);
        eoc_d  = (state_d == S_DONE);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            scnt_q  <= '0;
            k_q     <= '0;
            t_q     <= '0;
            cri_q   <= '0;
            crh_q   <= '0;
            crl_q   <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            eoc_q   <= 1'b0;
`ifdef SARADC_SAR_CTRL_CMP_SETTLE_EN
            ph_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            k_q     <= k_d;
            t_q     <= t_d;
            cri_q   <= cri_d;
            crh_q   <= crh_d;
            crl_q   <= crl_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            eoc_q   <= eoc_d;
`ifdef SARADC_SAR_CTRL_CMP_SETTLE_EN
            ph_q    <= ph_d;
`endif
        end
    end

    assign CRI  = cri_q;
    assign CRIB = ~cri_q;
    assign CRH  = crh_q;
    assign CRHB = ~crh_q;
    assign CRL  = crl_q;
    assign CRLB = ~crl_q;
    assign BUSY = busy_q;
    assign EOC  = eoc_q;
    assign DOUT = dout_q;

endmodule

// File: tb/tb_saradc_sar_ctrl.sv
// tb/tb_saradc_sar_ctrl.sv - vector-table bench for the SAR sequencer with a comparator model.
module tb_saradc_sar_ctrl;

    localparam int NB    = 8;
    localparam int NSAMP = 2;
`ifdef SARADC_SAR_CTRL_CMP_SETTLE_EN
    localparam int CPB = 2;
`else
    localparam int CPB = 1;
`endif
    localparam int LAT    = NSAMP + NB * CPB + 2;
    localparam int CONV0  = NSAMP + 2;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          START = 1'b0;
    logic          CMP = 1'b0;
    logic [NB-1:0] CRI, CRIB, CRH, CRHB, CRL, CRLB, DOUT;
    logic          BUSY, EOC;

    int n_vec = 0;
    int n_err = 0;

    saradc_sar_ctrl #(.NB(NB), .NSAMP(NSAMP)) dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .CMP(CMP),
        .CRI(CRI), .CRIB(CRIB), .CRH(CRH), .CRHB(CRHB), .CRL(CRL), .CRLB(CRLB),
        .BUSY(BUSY), .EOC(EOC), .DOUT(DOUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         mode;     // 0: CMP=(CRH>val), 1: CMP held 0, 2: CMP held 1
        logic [7:0] val;
        logic [7:0] exp_dout;
        int         pulse_c;  // cycle with an extra START pulse, 0 = none
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic model_cmp(input int mode, input logic [7:0] v, input logic [7:0] crh);
        if (mode == 1) return 1'b0;
        if (mode == 2) return 1'b1;
        return (crh > v);
    endfunction

    function automatic int bad_cycle();
        int b;
        b = 0;
        if (((CRI & CRH) | (CRI & CRL) | (CRH & CRL)) != '0) b++;
        if (CRIB !== ~CRI || CRHB !== ~CRH || CRLB !== ~CRL) b++;
        return b;
    endfunction

    function automatic logic settle_cycle(input int c);
`ifdef SARADC_SAR_CTRL_CMP_SETTLE_EN
        return (c >= CONV0) && (c < CONV0 + NB * CPB) && (((c - CONV0) % 2) == 0);
`else
        return (c < 0);
`endif
    endfunction

    // Called at a falling edge with the DUT idle; cycle c is observed after rising edge c-1.
    task automatic convert(input int mode, input logic [7:0] v, input int pulse_c,
                           output int eoc_c, output int eoc_n, output logic [7:0] d, output int bad);
        eoc_c = -1;
        eoc_n = 0;
        d     = '0;
        bad   = 0;
        START = 1'b1;
        for (int c = 1; c <= LAT + 6; c++) begin
            @(negedge CLK);
            START = (c == pulse_c);
            bad += bad_cycle();
            if (EOC) begin
                eoc_n++;
                if (eoc_c < 0) begin
                    eoc_c = c;
                    d     = DOUT;
                end
            end
            if (settle_cycle(c)) CMP = 1'($urandom_range(0, 1));
            else                 CMP = model_cmp(mode, v, CRH);
        end
        START = 1'b0;
    endtask

    vec_t       vecs[$];
    int         eoc_c, eoc_n, bad, nbusy;
    int         e1, e2;
    logic [7:0] d, d1, d2, v;

    initial begin
        vecs.push_back('{0, 8'hA5, 8'hA5, 0});
        vecs.push_back('{1, 8'h00, 8'hFF, 0});
        vecs.push_back('{2, 8'h00, 8'h00, 0});
        vecs.push_back('{0, 8'h00, 8'h00, 0});
        vecs.push_back('{0, 8'hFF, 8'hFF, 0});
        vecs.push_back('{0, 8'h80, 8'h80, 0});
        vecs.push_back('{0, 8'h7F, 8'h7F, 0});
        vecs.push_back('{0, 8'h3C, 8'h3C, 7});
        vecs.push_back('{0, 8'h01, 8'h01, CONV0 + 1});

        repeat (3) @(negedge CLK);
        check("rst_cri", CRI, 0);
        check("rst_crib", CRIB, 8'hFF);
        check("rst_crh", CRH, 0);
        check("rst_crhb", CRHB, 8'hFF);
        check("rst_crl", CRL, 0);
        check("rst_crlb", CRLB, 8'hFF);
        check("rst_busy", BUSY, 0);
        check("rst_eoc", EOC, 0);
        check("rst_dout", DOUT, 0);
        RSTN = 1'b1;
        @(negedge CLK);

        foreach (vecs[i]) begin
            convert(vecs[i].mode, vecs[i].val, vecs[i].pulse_c, eoc_c, eoc_n, d, bad);
            check($sformatf("v%0d_eoc_cycle", i), eoc_c, LAT);
            check($sformatf("v%0d_eoc_count", i), eoc_n, 1);
            check($sformatf("v%0d_dout_at_eoc", i), d, vecs[i].exp_dout);
            check($sformatf("v%0d_dout_held", i), DOUT, vecs[i].exp_dout);
            check($sformatf("v%0d_invariant", i), bad, 0);
            check($sformatf("v%0d_busy_after", i), BUSY, 0);
        end

        // Back-to-back: START held through the first DONE
        e1 = -1; e2 = -1; d1 = '0; d2 = '0; eoc_n = 0; nbusy = 0; bad = 0;
        v = 8'h3C;
        START = 1'b1;
        for (int c = 1; c <= 2 * LAT + 6; c++) begin
            @(negedge CLK);
            if (c == LAT + 8) START = 1'b0;
            if (c <= 2 * LAT && !BUSY) nbusy++;
            bad += bad_cycle();
            if (EOC) begin
                eoc_n++;
                if (e1 < 0) begin e1 = c; d1 = DOUT; end
                else if (e2 < 0) begin e2 = c; d2 = DOUT; end
            end
            if (c == LAT) v = 8'hC3;
            CMP = model_cmp(0, v, CRH);
        end
        START = 1'b0;
        check("b2b_eoc1", e1, LAT);
        check("b2b_eoc2", e2, 2 * LAT);
        check("b2b_dout1", d1, 8'h3C);
        check("b2b_dout2", d2, 8'hC3);
        check("b2b_eoc_count", eoc_n, 2);
        check("b2b_idle_gap", nbusy, 0);
        check("b2b_invariant", bad, 0);

        // Reset in the middle of CONV
        convert(0, 8'hA5, 0, eoc_c, eoc_n, d, bad);
        check("pre_rst_dout", DOUT, 8'hA5);
        START = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge CLK);
            START = 1'b0;
            CMP = model_cmp(0, 8'h5A, CRH);
        end
        check("mid_conv_active", (CRH | CRL) != '0, 1);
        RSTN = 1'b0;
        #1;
        check("arst_cri", CRI, 0);
        check("arst_crh", CRH, 0);
        check("arst_crl", CRL, 0);
        check("arst_compl", {CRIB, CRHB, CRLB}, 24'hFFFFFF);
        check("arst_busy", BUSY, 0);
        check("arst_eoc", EOC, 0);
        check("arst_dout", DOUT, 0);
        @(negedge CLK);
        RSTN = 1'b1;
        @(negedge CLK);
        convert(0, 8'h5A, 0, eoc_c, eoc_n, d, bad);
        check("post_rst_eoc_cycle", eoc_c, LAT);
        check("post_rst_eoc_count", eoc_n, 1);
        check("post_rst_dout", d, 8'h5A);
        check("post_rst_invariant", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
